// File: rtl/scc68070_pkg.sv
// Shared UART types and constants for the SCC68070 on-chip UART.
package scc68070_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int SAMPLE_LO  = 7;
   localparam int SAMPLE_HI  = 9;

   typedef struct packed {
      logic [1:0] channel_mode;
      logic       ctsn_enable;
      logic       parity_control;
      logic       parity_type;
      logic       stop_bit_length;
      logic       character_length;
   } uart_mode_t;

   typedef struct packed {
      logic received_break;
      logic framing_error;
      logic parity_error;
      logic overrun_error;
      logic tx_empty;
      logic tx_ready;
      logic reserved;
      logic rx_ready;
   } uart_status_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one tick every div+1 clocks while run is high.
module uart_os_tick #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   // Down-counter held at reload while stopped, so the first tick of a frame lands div+1 clocks in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt <= '0;
      else if (!run || cnt == '0) cnt <= div;
      else                        cnt <= cnt - DIV_W'(1);
   end

   assign tick = run && (cnt == '0);

endmodule

// File: rtl/scc68070_uart_rx.sv
// SCC68070 UART receiver: 16x oversampled deserialiser with holding register and error flags.
module scc68070_uart_rx
   import scc68070_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_pin,
   input  logic [DIV_W-1:0] os_div,
   input  logic             char_len8,
   input  logic             parity_en,
   input  logic             parity_odd,
   output logic [7:0]       rx_data,
   output logic             rx_data_valid,
   input  logic             rx_data_ready,
   output logic             parity_error,
   output logic             framing_error,
   output logic             received_break,
   output logic             overrun_error,
   input  logic             clear_errors
);

   localparam logic [3:0] SC_LO  = 4'(SAMPLE_LO);
   localparam logic [3:0] SC_MID = 4'(SAMPLE_LO + 1);
   localparam logic [3:0] SC_HI  = 4'(SAMPLE_HI);
   localparam logic [3:0] SC_END = 4'(OVERSAMPLE - 1);

   rx_state_e  state, state_nx;
   logic       sync1, rxs, rxs_d;
   logic       tick, run, start_det, done, maj;
   logic       s7, s8, brk_wait;
   logic [3:0] sc, bc;
   logic [7:0] shreg, rx_char;
   logic       par_bit, len8_q, pen_q, podd_q;
   logic       perr, ferr, brk;

   uart_os_tick #(.DIV_W(DIV_W)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .div   (os_div),
      .tick  (tick)
   );

   // Two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         sync1 <= rx_pin;
         rxs   <= sync1;
         rxs_d <= rxs;
      end
   end

   // The tick counter also runs in IDLE while timing the post-break idle bit
   assign run       = (state != RX_IDLE) || brk_wait;
   assign start_det = (state == RX_IDLE) && !brk_wait && rxs_d && !rxs;
   assign maj       = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RX_IDLE;
      else        state <= state_nx;
   end

   // FSM next state; done marks the stop-bit majority decision
   always_comb begin
      state_nx = state;
      done     = 1'b0;
      case (state)
         RX_IDLE:   if (start_det) state_nx = RX_START;
         RX_START:  if (tick) begin
                       if (sc == SC_HI && maj) state_nx = RX_IDLE;
                       else if (sc == SC_END)  state_nx = RX_DATA;
                    end
         RX_DATA:   if (tick && sc == SC_END && bc == (len8_q ? 4'd8 : 4'd7))
                       state_nx = pen_q ? RX_PARITY : RX_STOP;
         RX_PARITY: if (tick && sc == SC_END) state_nx = RX_STOP;
         RX_STOP:   if (tick && sc == SC_HI) begin
                       done     = 1'b1;
                       state_nx = RX_IDLE;
                    end
         default:   state_nx = RX_IDLE;
      endcase
   end

   // Sample/bit counters, shift register, mode latch and post-break idle timer.
   // brk_wait is set by reset too, so the line must be seen idle for a bit before the first start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc       <= '0;
         bc       <= '0;
         s7       <= 1'b1;
         s8       <= 1'b1;
         shreg    <= '0;
         par_bit  <= 1'b0;
         len8_q   <= 1'b0;
         pen_q    <= 1'b0;
         podd_q   <= 1'b0;
         brk_wait <= 1'b1;
      end else if (state == RX_IDLE) begin
         if (brk_wait) begin
            if (!rxs)       sc <= '0;
            else if (tick) begin
               if (sc == SC_END) brk_wait <= 1'b0;
               sc <= sc + 4'd1;
            end
         end else if (start_det) begin
            sc    <= '0;
            bc    <= '0;
            shreg <= '0;
         end
      end else if (tick) begin
         sc <= sc + 4'd1;
         if (sc == SC_LO)  s7 <= rxs;
         if (sc == SC_MID) s8 <= rxs;
         if (sc == SC_HI) begin
            case (state)
               RX_DATA: begin
                  shreg <= {maj, shreg[7:1]};
                  bc    <= bc + 4'd1;
               end
               RX_PARITY: par_bit <= maj;
               RX_STOP:   if (brk) brk_wait <= 1'b1;
               default: ;
            endcase
         end
         if (state == RX_START && sc == SC_END) begin
            len8_q <= char_len8;
            pen_q  <= parity_en;
            podd_q <= parity_odd;
         end
      end
   end

   // 7-bit characters end up in shreg[7:1]; the unshifted bit 0 is always zero
   assign rx_char = len8_q ? shreg : {1'b0, shreg[7:1]};
   assign perr    = pen_q && (par_bit != ((^shreg) ^ podd_q));
   assign ferr    = !maj;
   assign brk     = !maj && (shreg == 8'h00) && !(pen_q && par_bit);

   // Holding register, per-character flags and sticky overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data        <= '0;
         rx_data_valid  <= 1'b0;
         parity_error   <= 1'b0;
         framing_error  <= 1'b0;
         received_break <= 1'b0;
         overrun_error  <= 1'b0;
      end else begin
         if (done && (!rx_data_valid || rx_data_ready)) begin
            rx_data        <= rx_char;
            parity_error   <= perr;
            framing_error  <= ferr;
            received_break <= brk;
            rx_data_valid  <= 1'b1;
         end else if (rx_data_ready) begin
            rx_data_valid  <= 1'b0;
         end
         if (done && rx_data_valid && !rx_data_ready) overrun_error <= 1'b1;
         else if (clear_errors)                       overrun_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_scc68070_uart_rx.sv
// Self-checking bench for scc68070_uart_rx at os_div=3 (64 clk per bit).
module tb_scc68070_uart_rx;

   localparam int BIT = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_pin = 1'b1;
   logic [7:0] os_div = 8'd3;
   logic       char_len8 = 1'b1, parity_en = 1'b0, parity_odd = 1'b0;
   logic [7:0] rx_data;
   logic       rx_data_valid, rx_data_ready = 1'b0;
   logic       parity_error, framing_error, received_break, overrun_error;
   logic       clear_errors = 1'b0;

   int tests = 0;
   int fails = 0;
   int rx_count = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       pe, fe, brk;
   } exp_t;

   typedef struct {
      logic [7:0] d;
      logic       len8, pen, podd, pbit, stopb;
      exp_t       e;
   } vec_t;

   exp_t expq[$];
   exp_t mon_e;
   logic vprev = 1'b0;
   vec_t vecs[8];

   scc68070_uart_rx #(.DIV_W(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_pin         (rx_pin),
      .os_div         (os_div),
      .char_len8      (char_len8),
      .parity_en      (parity_en),
      .parity_odd     (parity_odd),
      .rx_data        (rx_data),
      .rx_data_valid  (rx_data_valid),
      .rx_data_ready  (rx_data_ready),
      .parity_error   (parity_error),
      .framing_error  (framing_error),
      .received_break (received_break),
      .overrun_error  (overrun_error),
      .clear_errors   (clear_errors)
   );

   always #5 clk = ~clk;

   // Monitor: each new character (valid rising) is checked against the scoreboard
   always @(negedge clk) begin
      if (rx_data_valid && !vprev) begin
         rx_count++;
         tests++;
         if (expq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_char: got d=%h pe=%b fe=%b brk=%b, none expected",
                     rx_data, parity_error, framing_error, received_break);
         end else begin
            mon_e = expq.pop_front();
            if ({rx_data, parity_error, framing_error, received_break} != mon_e) begin
               fails++;
               $display("FAIL char: got d=%h pe=%b fe=%b brk=%b want d=%h pe=%b fe=%b brk=%b",
                        rx_data, parity_error, framing_error, received_break,
                        mon_e.d, mon_e.pe, mon_e.fe, mon_e.brk);
            end
         end
      end
      vprev = rx_data_valid;
   end

   function automatic vec_t mk(input logic [7:0] d, input logic len8, pen, podd, pbit, stopb,
                               input logic [7:0] ed, input logic epe, efe, ebrk);
      vec_t v;
      v.d = d; v.len8 = len8; v.pen = pen; v.podd = podd; v.pbit = pbit; v.stopb = stopb;
      v.e = '{ed, epe, efe, ebrk};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic bit_time(input logic b, input int n);
      rx_pin = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic len8, pen, pbit, stopb);
      bit_time(1'b0, BIT);
      for (int i = 0; i < (len8 ? 8 : 7); i++) bit_time(d[i], BIT);
      if (pen) bit_time(pbit, BIT);
      bit_time(stopb, BIT);
      bit_time(1'b1, 16);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!rx_data_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, rx_data_valid}, 32'd1);
   endtask

   task automatic pulse_ready();
      rx_data_ready = 1'b1;
      @(negedge clk);
      rx_data_ready = 1'b0;
      @(negedge clk);
      check("ready_clears_valid", {31'd0, rx_data_valid}, 32'd0);
   endtask

   initial begin
      int c0;
      vecs[0] = mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      vecs[1] = mk(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
      vecs[2] = mk(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
      vecs[3] = mk(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0);
      vecs[4] = mk(8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0);
      vecs[5] = mk(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
      vecs[6] = mk(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      vecs[7] = mk(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {20'd0, rx_data, rx_data_valid, parity_error, framing_error, received_break, overrun_error},
            32'd0);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);

      // Table-driven frames
      foreach (vecs[i]) begin
         char_len8  = vecs[i].len8;
         parity_en  = vecs[i].pen;
         parity_odd = vecs[i].podd;
         expq.push_back(vecs[i].e);
         send_frame(vecs[i].d, vecs[i].len8, vecs[i].pen, vecs[i].pbit, vecs[i].stopb);
         wait_valid("vec_valid");
         pulse_ready();
         repeat (20) @(negedge clk);
      end
      char_len8 = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;

      // Break: line low for 20 bit times gives exactly one break character
      c0 = rx_count;
      expq.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
      bit_time(1'b0, 20 * BIT);
      check("break_one_char", rx_count, c0 + 1);
      bit_time(1'b1, 16);
      pulse_ready();
      repeat (100) @(negedge clk);

      // Overrun: second frame discarded, holding register keeps 0x11
      expq.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_valid("ovr_first_valid");
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
      check("ovr_data_kept", {24'd0, rx_data}, 32'h11);
      check("ovr_flag_set", {31'd0, overrun_error}, 32'd1);
      clear_errors = 1'b1;
      @(negedge clk);
      clear_errors = 1'b0;
      check("ovr_cleared", {31'd0, overrun_error}, 32'd0);
      check("valid_held", {31'd0, rx_data_valid}, 32'd1);
      pulse_ready();
      check("data_held_after_ready", {24'd0, rx_data}, 32'h11);
      repeat (20) @(negedge clk);

      // Start glitch of one tick, then a real frame
      c0 = rx_count;
      bit_time(1'b0, 4);
      bit_time(1'b1, BIT);
      check("glitch_no_char", rx_count, c0);
      expq.push_back('{8'h55, 1'b0, 1'b0, 1'b0});
      send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_valid("glitch_then_55");

      // Reset during bit 3 of 0xF0 (0x55 left in the holding register)
      bit_time(1'b0, BIT);
      for (int i = 0; i < 3; i++) bit_time(1'b0, BIT);
      bit_time(1'b0, BIT / 2);
      rst_n = 1'b0;
      #1;
      check("midframe_reset_outputs",
            {20'd0, rx_data, rx_data_valid, parity_error, framing_error, received_break, overrun_error},
            32'd0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      c0 = rx_count;
      bit_time(1'b0, BIT / 2);
      bit_time(1'b1, 5 * BIT);
      bit_time(1'b1, 200);
      check("aborted_frame_silent", rx_count, c0);
      expq.push_back('{8'h80, 1'b0, 1'b0, 1'b0});
      send_frame(8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_valid("after_reset_80");
      pulse_ready();
      repeat (20) @(negedge clk);

      check("scoreboard_drained", expq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
